// File: rtl/counter.sv
// counter: parameterised synchronous binary up/down counter with enable,
// asynchronous active-low reset and modulo-2^WIDTH wrap-around.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset; clears count and wrap at once
//   en       count enable: 1 = step on this edge, 0 = hold
//   up_down  direction, sampled only when en=1: 1 = increment, 0 = decrement
//   count    registered count value
//   at_max   decode of count == 2^WIDTH-1
//   at_min   decode of count == 0
//   wrap     registered one-cycle pulse on the edge that wraps the count
module counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  // A wrap is detected from the pre-step value so the pulse lands on the
  // same edge that performs the wrapping step.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (en) begin
      if (up_down) begin
        count_next = count + ONE;
        wrap_next  = (count == MAX_VAL);
      end else begin
        count_next = count - ONE;
        wrap_next  = (count == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_counter.sv
module tb_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_down;
  logic [W-1:0] count;
  logic         at_max;
  logic         at_min;
  logic         wrap;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] c;
    logic         w;
    string        name;
  } exp_t;

  exp_t sb[$];

  counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_down (up_down),
    .count   (count),
    .at_max  (at_max),
    .at_min  (at_min),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endfunction

  // Full output check for one expected state; at_max/at_min follow count.
  function automatic void chk_all(input exp_t e);
    chk({e.name, ".count"},  int'(count),  int'(e.c));
    chk({e.name, ".wrap"},   int'(wrap),   int'(e.w));
    chk({e.name, ".at_max"}, int'(at_max), (e.c == 4'd15) ? 1 : 0);
    chk({e.name, ".at_min"}, int'(at_min), (e.c == 4'd0)  ? 1 : 0);
  endfunction

  // Monitor: after every rising edge, compare against any queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_all(e);
      end
    end
  end

  // Called at a negedge: drive inputs for the next edge, queue the result.
  task automatic step(input logic e_in, input logic ud, input int exp_c,
                      input logic exp_w, input string name);
    exp_t e;
    en      = e_in;
    up_down = ud;
    e.c     = exp_c[W-1:0];
    e.w     = exp_w;
    e.name  = name;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t ez;
    ez.c = '0; ez.w = 1'b0;

    // Reset held across two edges with counting requested.
    rst = 1'b0; en = 1'b1; up_down = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ez.name = "reset_hold";
    chk_all(ez);
    rst = 1'b1;

    // Up count through the 15->0 wrap.
    for (int i = 1; i <= 17; i++)
      step(1'b1, 1'b1, i % 16, (i == 16), "up");

    // Up to 3, then hold.
    step(1'b1, 1'b1, 2, 1'b0, "up_to3");
    step(1'b1, 1'b1, 3, 1'b0, "up_to3");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 3, 1'b0, "hold");
    step(1'b1, 1'b1, 4, 1'b0, "reenable");

    // Down from 4 through the 0->15 underflow.
    step(1'b1, 1'b0, 3,  1'b0, "down");
    step(1'b1, 1'b0, 2,  1'b0, "down");
    step(1'b1, 1'b0, 1,  1'b0, "down");
    step(1'b1, 1'b0, 0,  1'b0, "down");
    step(1'b1, 1'b0, 15, 1'b1, "underflow");
    step(1'b1, 1'b0, 14, 1'b0, "down");

    // Down to 7, then direction changes on consecutive edges.
    for (int v = 13; v >= 7; v--)
      step(1'b1, 1'b0, v, 1'b0, "down_to7");
    step(1'b1, 1'b1, 8, 1'b0, "dir");
    step(1'b1, 1'b1, 9, 1'b0, "dir");
    step(1'b1, 1'b0, 8, 1'b0, "dir");
    step(1'b1, 1'b0, 7, 1'b0, "dir");
    step(1'b1, 1'b0, 6, 1'b0, "dir");

    // Reset pulse while disabled at 6; release with counting enabled.
    en = 1'b0;
    #1 rst = 1'b0;
    #1;
    ez.name = "rst_disabled";
    chk_all(ez);
    @(negedge clk);
    ez.name = "rst_disabled_held";
    chk_all(ez);
    rst = 1'b1;
    step(1'b1, 1'b1, 1, 1'b0, "after_rst");
    step(1'b1, 1'b1, 2, 1'b0, "after_rst");
    step(1'b1, 1'b1, 3, 1'b0, "after_rst");
    step(1'b1, 1'b1, 4, 1'b0, "after_rst");
    step(1'b1, 1'b1, 5, 1'b0, "after_rst");

    // Reset asserted between edges at 5 must clear without a clock.
    #2 rst = 1'b0;
    #1;
    ez.name = "rst_async";
    chk_all(ez);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b1, 1, 1'b0, "resume");

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
